// File: rtl/x_corr_pkg.sv
// x_corr_pkg
// Shared types and helpers for the cross-correlator slice.
//   corrStateT   : RUN while windows are being accumulated, HOLD while a result
//                  waits for the downstream handshake
//   PIPE_LATENCY : stages between an accepted sample and its effect on the
//                  reported peak (product, accumulate, magnitude, compare)
//   satAdd       : signed add clamped to a given bit width, used by the
//                  accumulators when X_CORR_SATURATE_EN is defined
package x_corr_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } corrStateT;

   localparam int PIPE_LATENCY = 4;

   // Adds two sign-extended operands at 65 bits so the true sum is never lost,
   // then clamps it to the signed range of 'width' bits (width <= 63).
   function automatic logic signed [63:0] satAdd(
      input logic signed [63:0] a,
      input logic signed [63:0] b,
      input int                 width
   );
      logic signed [64:0] sum;
      logic signed [64:0] hiLimit;
      logic signed [64:0] loLimit;
      sum     = $signed({a[63], a}) + $signed({b[63], b});
      hiLimit = (65'sd1 <<< (width - 1)) - 65'sd1;
      loLimit = -hiLimit - 65'sd1;
      if (sum > hiLimit) begin
         return hiLimit[63:0];
      end else if (sum < loLimit) begin
         return loLimit[63:0];
      end else begin
         return sum[63:0];
      end
   endfunction

endpackage

// File: rtl/x_corr_core_mac.sv
// cmplx_conj_mac
// Registers x*conj(y) for one sample pair and folds it into a pair of window
// accumulators on the following cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_clear           : synchronous clear of product stage and accumulators
//   i_valid           : sample pair accepted this cycle
//   i_first           : accepted sample opens a new window (load, not add)
//   i_xi/i_xq         : reference sample, real/imaginary (signed)
//   i_yi/i_yq         : capture sample, real/imaginary (signed)
//   o_accI/o_accQ     : running window sums (signed)
// Build option: X_CORR_SATURATE_EN makes the accumulators clamp at their signed
// limits instead of wrapping.
module cmplx_conj_mac
   import x_corr_pkg::*;
#(
   parameter int xi_bits    = 8,
   parameter int xq_bits    = 8,
   parameter int yi_bits    = 8,
   parameter int yq_bits    = 8,
   parameter int acc_i_bits = 24,
   parameter int acc_q_bits = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_valid,
   input  logic                  i_first,
   input  logic [xi_bits-1:0]    i_xi,
   input  logic [xq_bits-1:0]    i_xq,
   input  logic [yi_bits-1:0]    i_yi,
   input  logic [yq_bits-1:0]    i_yq,
   output logic [acc_i_bits-1:0] o_accI,
   output logic [acc_q_bits-1:0] o_accQ
);

   localparam int W_A       = xi_bits + yi_bits;
   localparam int W_B       = xq_bits + yq_bits;
   localparam int W_C       = xq_bits + yi_bits;
   localparam int W_D       = xi_bits + yq_bits;
   localparam int W_AB      = (W_A > W_B) ? W_A : W_B;
   localparam int W_CD      = (W_C > W_D) ? W_C : W_D;
   localparam int PROD_BITS = ((W_AB > W_CD) ? W_AB : W_CD) + 1;

   logic signed [PROD_BITS-1:0]  w_xiExt;
   logic signed [PROD_BITS-1:0]  w_xqExt;
   logic signed [PROD_BITS-1:0]  w_yiExt;
   logic signed [PROD_BITS-1:0]  w_yqExt;
   logic signed [PROD_BITS-1:0]  w_prodI;
   logic signed [PROD_BITS-1:0]  w_prodQ;
   logic signed [PROD_BITS-1:0]  r_prodI;
   logic signed [PROD_BITS-1:0]  r_prodQ;
   logic                         r_prodValid;
   logic                         r_prodFirst;
   logic signed [acc_i_bits-1:0] r_accI;
   logic signed [acc_q_bits-1:0] r_accQ;
   logic signed [acc_i_bits-1:0] w_nextI;
   logic signed [acc_q_bits-1:0] w_nextQ;
`ifdef X_CORR_SATURATE_EN
   logic signed [63:0]           w_satI;
   logic signed [63:0]           w_satQ;
`endif

   // Complex multiply by the conjugate of y. Every operand is sign-extended to
   // the full product width first, so the products and the final add/subtract
   // can never overflow.
   always_comb begin
      w_xiExt = PROD_BITS'($signed(i_xi));
      w_xqExt = PROD_BITS'($signed(i_xq));
      w_yiExt = PROD_BITS'($signed(i_yi));
      w_yqExt = PROD_BITS'($signed(i_yq));
      w_prodI = w_xiExt * w_yiExt + w_xqExt * w_yqExt;
      w_prodQ = w_xqExt * w_yiExt - w_xiExt * w_yqExt;
   end

   // Stage 1: capture the product of each accepted pair together with a
   // window-start flag. The valid flag is a one-cycle pulse that makes the
   // accumulator act on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prodI     <= '0;
         r_prodQ     <= '0;
         r_prodValid <= 1'b0;
         r_prodFirst <= 1'b0;
      end else if (i_clear) begin
         r_prodI     <= '0;
         r_prodQ     <= '0;
         r_prodValid <= 1'b0;
         r_prodFirst <= 1'b0;
      end else begin
         r_prodValid <= i_valid;
         if (i_valid) begin
            r_prodI     <= w_prodI;
            r_prodQ     <= w_prodQ;
            r_prodFirst <= i_first;
         end
      end
   end

   // Next accumulator value. A window's first product is added to zero
   // instead of the old sum, which turns the add into a load without a second
   // datapath. The product is resized to the accumulator width. With the
   // saturation option the result clamps; otherwise it wraps modulo 2^width.
   always_comb begin
`ifdef X_CORR_SATURATE_EN
      w_satI  = satAdd(r_prodFirst ? 64'sd0 : 64'(r_accI), 64'(r_prodI), acc_i_bits);
      w_satQ  = satAdd(r_prodFirst ? 64'sd0 : 64'(r_accQ), 64'(r_prodQ), acc_q_bits);
      w_nextI = acc_i_bits'(w_satI);
      w_nextQ = acc_q_bits'(w_satQ);
`else
      w_nextI = (r_prodFirst ? '0 : r_accI) + acc_i_bits'(r_prodI);
      w_nextQ = (r_prodFirst ? '0 : r_accQ) + acc_q_bits'(r_prodQ);
`endif
   end

   // Stage 2: the accumulators only move when a registered product is
   // present, so input gaps simply leave the partial sums untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_accI <= '0;
         r_accQ <= '0;
      end else if (i_clear) begin
         r_accI <= '0;
         r_accQ <= '0;
      end else if (r_prodValid) begin
         r_accI <= w_nextI;
         r_accQ <= w_nextQ;
      end
   end

   assign o_accI = r_accI;
   assign o_accQ = r_accQ;

endmodule

// File: rtl/x_corr_core.sv
// x_corr_core
// Streaming complex cross-correlator with peak detection. Over num_lags windows
// of 'length' accepted samples it sums x*conj(y) per window, takes |sum|^2 and
// reports the largest value and the lag (window index) that produced it.
//   clk, rst_n         : clock, asynchronous active-low reset
//   xi, xq, yi, yq     : reference (x) and capture (y) sample, signed
//   m_axis_tvalid      : input sample pair valid
//   s_axis_tready      : block accepts a sample pair (RUN state)
//   s_axis_tvalid      : result valid (HOLD state)
//   m_axis_tready      : downstream takes the result
//   out_max            : peak magnitude-squared, saturated to out_max_bits
//   index              : lag index of the peak
// Build option: X_CORR_SATURATE_EN (see cmplx_conj_mac) selects saturating
// window accumulators; by default they wrap.
module x_corr_core
   import x_corr_pkg::*;
#(
   parameter int xi_bits             = 8,
   parameter int xq_bits             = 8,
   parameter int yi_bits             = 8,
   parameter int yq_bits             = 8,
   parameter int i_bits              = 24,
   parameter int q_bits              = 24,
   parameter int length              = 16,
   parameter int length_counter_bits = 4,
   parameter int num_lags            = length + 1,
   parameter int out_max_bits        = 48
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [xi_bits-1:0]           xi,
   input  logic [xq_bits-1:0]           xq,
   input  logic [yi_bits-1:0]           yi,
   input  logic [yq_bits-1:0]           yq,
   input  logic                         m_axis_tvalid,
   output logic                         s_axis_tready,
   output logic                         s_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [out_max_bits-1:0]      out_max,
   output logic [length_counter_bits:0] index
);

   localparam int LAG_BITS  = length_counter_bits + 1;
   localparam int TAG_LAST  = PIPE_LATENCY - 1;
   localparam int ACC_BITS  = (i_bits > q_bits) ? i_bits : q_bits;
   localparam int SQ_BITS   = 2 * ACC_BITS;
   localparam int MAG_BITS  = SQ_BITS + 1;
   localparam int WIDE_BITS = (MAG_BITS > out_max_bits) ? MAG_BITS : out_max_bits;
   localparam logic [length_counter_bits-1:0] SAMPLE_LAST = length_counter_bits'(length - 1);
   localparam logic [LAG_BITS-1:0]            LAG_END     = LAG_BITS'(num_lags);
   localparam logic [LAG_BITS-1:0]            LAG_FINAL   = LAG_BITS'(num_lags - 1);

   corrStateT                        r_state;
   corrStateT                        w_nextState;
   logic                             r_readyEn;
   logic                             w_accept;
   logic                             w_release;
   logic                             w_finalDone;
   logic [length_counter_bits-1:0]   r_sampleCount;
   logic [LAG_BITS-1:0]              r_lagCount;
   logic                             r_s1Valid;
   logic                             r_s1Last;
   logic                             r_s2Done;
   logic                             r_s3Done;
   logic [LAG_BITS-1:0]              r_lagPipe [1:TAG_LAST];
   logic [i_bits-1:0]                w_accI;
   logic [q_bits-1:0]                w_accQ;
   logic signed [SQ_BITS-1:0]        w_extI;
   logic signed [SQ_BITS-1:0]        w_extQ;
   logic [SQ_BITS-1:0]               w_sqI;
   logic [SQ_BITS-1:0]               w_sqQ;
   logic [WIDE_BITS-1:0]             w_magWide;
   logic [WIDE_BITS-1:0]             w_magLimit;
   logic [out_max_bits-1:0]          w_magSat;
   logic [out_max_bits-1:0]          r_mag;
   logic [out_max_bits-1:0]          r_max;
   logic [LAG_BITS-1:0]              r_index;

   // Handshake decode. A release is the downstream taking the held result;
   // it clears the whole correlation so the next run starts from lag 0.
   // The final window is recognised when its magnitude reaches the compare
   // stage, which is the same edge that raises the result valid.
   always_comb begin
      w_accept    = m_axis_tvalid && s_axis_tready;
      w_release   = s_axis_tvalid && m_axis_tready;
      w_finalDone = r_s3Done && (r_lagPipe[TAG_LAST] == LAG_FINAL);
   end

   // Keeps tready low while reset is held and lets it rise on the first clock
   // after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_readyEn <= 1'b0;
      end else begin
         r_readyEn <= 1'b1;
      end
   end

   // Sample and lag counters. The sample counter wraps at the end of every
   // window; the lag counter stops at num_lags, a value that never matches a
   // real window. Samples that arrive after the last window but before HOLD is
   // entered land in that phantom window and are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sampleCount <= '0;
         r_lagCount    <= '0;
      end else if (w_release) begin
         r_sampleCount <= '0;
         r_lagCount    <= '0;
      end else if (w_accept) begin
         if (r_sampleCount == SAMPLE_LAST) begin
            r_sampleCount <= '0;
            if (r_lagCount != LAG_END) begin
               r_lagCount <= r_lagCount + LAG_BITS'(1);
            end
         end else begin
            r_sampleCount <= r_sampleCount + length_counter_bits'(1);
         end
      end
   end

   cmplx_conj_mac #(
      .xi_bits    (xi_bits),
      .xq_bits    (xq_bits),
      .yi_bits    (yi_bits),
      .yq_bits    (yq_bits),
      .acc_i_bits (i_bits),
      .acc_q_bits (q_bits)
   ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_release),
      .i_valid (w_accept),
      .i_first (r_sampleCount == '0),
      .i_xi    (xi),
      .i_xq    (xq),
      .i_yi    (yi),
      .i_yq    (yq),
      .o_accI  (w_accI),
      .o_accQ  (w_accQ)
   );

   // Control tags that travel beside the datapath. Each done flag is a
   // one-cycle pulse, so the lag tags can shift every cycle and still line up
   // with the data they describe, whatever the gaps in the input stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_s1Last  <= 1'b0;
         r_s2Done  <= 1'b0;
         r_s3Done  <= 1'b0;
         for (int k = 1; k <= TAG_LAST; k++) begin
            r_lagPipe[k] <= '0;
         end
      end else if (w_release) begin
         r_s1Valid <= 1'b0;
         r_s1Last  <= 1'b0;
         r_s2Done  <= 1'b0;
         r_s3Done  <= 1'b0;
         for (int k = 1; k <= TAG_LAST; k++) begin
            r_lagPipe[k] <= '0;
         end
      end else begin
         r_s1Valid <= w_accept;
         if (w_accept) begin
            r_s1Last     <= (r_sampleCount == SAMPLE_LAST);
            r_lagPipe[1] <= r_lagCount;
         end
         r_s2Done <= r_s1Valid && r_s1Last && (r_lagPipe[1] != LAG_END);
         r_s3Done <= r_s2Done;
         for (int k = 2; k <= TAG_LAST; k++) begin
            r_lagPipe[k] <= r_lagPipe[k-1];
         end
      end
   end

   // Magnitude-squared at full precision. The accumulators are sign-extended
   // before squaring so the square is exact; the two non-negative squares are
   // then summed with one spare bit and clamped to all-ones if they exceed the
   // output width.
   always_comb begin
      w_extI     = SQ_BITS'($signed(w_accI));
      w_extQ     = SQ_BITS'($signed(w_accQ));
      w_sqI      = SQ_BITS'(w_extI * w_extI);
      w_sqQ      = SQ_BITS'(w_extQ * w_extQ);
      w_magWide  = WIDE_BITS'(w_sqI) + WIDE_BITS'(w_sqQ);
      w_magLimit = '0;
      w_magLimit[out_max_bits-1:0] = '1;
      w_magSat   = (w_magWide > w_magLimit) ? '1 : out_max_bits'(w_magWide);
   end

   // Stage 3: register the magnitude of a window the cycle after its sum is
   // complete. The next window may already be loading into the accumulators
   // on this same edge, which is how consecutive windows overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mag <= '0;
      end else if (w_release) begin
         r_mag <= '0;
      end else if (r_s2Done) begin
         r_mag <= w_magSat;
      end
   end

   // Stage 4: running peak. The strict compare keeps the earliest lag on
   // ties, and starting from zero means an all-zero input reports lag 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_max   <= '0;
         r_index <= '0;
      end else if (w_release) begin
         r_max   <= '0;
         r_index <= '0;
      end else if (r_s3Done && (r_mag > r_max)) begin
         r_max   <= r_mag;
         r_index <= r_lagPipe[TAG_LAST];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next state: enter HOLD when the final window's peak is decided, and
   // return to RUN once the downstream takes the result.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         RUN:     if (w_finalDone)   w_nextState = HOLD;
         HOLD:    if (m_axis_tready) w_nextState = RUN;
         default: w_nextState = RUN;
      endcase
   end

   // FSM outputs. Result valid is simply the HOLD state, so it rises and
   // tready falls on the same edge.
   always_comb begin
      s_axis_tready = r_readyEn && (r_state == RUN);
      s_axis_tvalid = (r_state == HOLD);
      out_max       = r_max;
      index         = r_index;
   end

endmodule

// File: tb/tb_x_corr_core.sv
// tb_x_corr_core
// Directed bench for x_corr_core with length=4, num_lags=5 and 8-bit
// accumulators. Expected results are pushed into a queue when each run is
// started; a monitor pops and compares them on every result handshake.
// Build option: X_CORR_SATURATE_EN changes the expected value of the
// accumulator overflow run.
module tb_x_corr_core;
   import x_corr_pkg::*;

   localparam int LEN  = 4;
   localparam int LCB  = 2;
   localparam int LAGS = 5;
   localparam int OUTW = 48;

   typedef struct {
      longint maxVal;
      longint idx;
   } resultT;

   logic            clk;
   logic            rst_n;
   logic [7:0]      xi;
   logic [7:0]      xq;
   logic [7:0]      yi;
   logic [7:0]      yq;
   logic            m_axis_tvalid;
   logic            s_axis_tready;
   logic            s_axis_tvalid;
   logic            m_axis_tready;
   logic [OUTW-1:0] out_max;
   logic [LCB:0]    index;

   resultT expQ[$];
   int     total = 0;
   int     bad   = 0;
   bit     gapsOn = 1'b0;

   x_corr_core #(
      .xi_bits             (8),
      .xq_bits             (8),
      .yi_bits             (8),
      .yq_bits             (8),
      .i_bits              (8),
      .q_bits              (8),
      .length              (LEN),
      .length_counter_bits (LCB),
      .num_lags            (LAGS),
      .out_max_bits        (OUTW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .xi            (xi),
      .xq            (xq),
      .yi            (yi),
      .yq            (yq),
      .m_axis_tvalid (m_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tvalid (s_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .out_max       (out_max),
      .index         (index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input longint actual, input longint expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Scoreboard monitor: every result handshake must match the oldest
   // expected result.
   always @(negedge clk) begin
      resultT e;
      if (rst_n && s_axis_tvalid && m_axis_tready) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected result: got max=%0d idx=%0d, required no result", out_max, index);
         end else begin
            e = expQ.pop_front();
            checkOutput("out_max", longint'(out_max), e.maxVal);
            checkOutput("index", longint'(index), e.idx);
         end
      end
   end

   task automatic expectResult(input longint maxVal, input longint idx);
      resultT e;
      e.maxVal = maxVal;
      e.idx    = idx;
      expQ.push_back(e);
   endtask

   // Offers one sample pair, optionally after a few idle cycles, and returns
   // just after the edge that accepts it.
   task automatic applyStimulus(input int xr, input int xim, input int yr, input int yim);
      if (gapsOn) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      xi = 8'(xr);
      xq = 8'(xim);
      yi = 8'(yr);
      yq = 8'(yim);
      m_axis_tvalid = 1'b1;
      @(posedge clk);
      #1;
      m_axis_tvalid = 1'b0;
   endtask

   task automatic sendWindow(input int xr, input int xim, input int yr, input int yim);
      repeat (LEN) applyStimulus(xr, xim, yr, yim);
   endtask

   task automatic sendRun(input int xr, input int xim, input int yr, input int yim);
      repeat (LAGS) sendWindow(xr, xim, yr, yim);
   endtask

   // Counts edges from the accepting edge of the last sample until the result
   // is valid (bounded), then checks the handshake returns the block to RUN.
   task automatic awaitResult();
      int edges;
      edges = 1;
      while (!s_axis_tvalid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checkOutput("latency", edges, PIPE_LATENCY);
      checkOutput("tready in HOLD", s_axis_tready, 0);
      if (m_axis_tready) begin
         @(posedge clk);
         #1;
         checkOutput("tready after release", s_axis_tready, 1);
         checkOutput("tvalid after release", s_axis_tvalid, 0);
         checkOutput("max after release", longint'(out_max), 0);
      end
   endtask

   // Window 2 uses x=(2,1): sum (8,4) gives 80, other windows give 16.
   task automatic sendPeakRun();
      sendWindow(1, 0, 1, 0);
      sendWindow(1, 0, 1, 0);
      sendWindow(2, 1, 1, 0);
      sendWindow(1, 0, 1, 0);
      sendWindow(1, 0, 1, 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      xi = '0;
      xq = '0;
      yi = '0;
      yq = '0;
      #12;
      checkOutput("reset out_max", longint'(out_max), 0);
      checkOutput("reset index", longint'(index), 0);
      checkOutput("reset tvalid", s_axis_tvalid, 0);
      checkOutput("reset tready", s_axis_tready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("tready after reset", s_axis_tready, 1);

      $display("[TB] all-zero input");
      expectResult(0, 0);
      sendRun(0, 0, 0, 0);
      awaitResult();

      $display("[TB] constant x=y=(1,0), ties keep lag 0");
      expectResult(16, 0);
      sendRun(1, 0, 1, 0);
      awaitResult();

      $display("[TB] peak in window 2");
      expectResult(80, 2);
      sendPeakRun();
      awaitResult();

      $display("[TB] conjugate checks");
      expectResult(16, 0);
      sendRun(0, 1, 1, 0);
      awaitResult();
      expectResult(16, 0);
      sendRun(1, 0, 0, 1);
      awaitResult();
      // A=(1,0)*conj(0,1) -> (0,-1), B=(0,1)*conj(1,0) -> (0,+1).
      // Balanced windows sum to 0; window 3 (A,A,A,B) gives (0,-2) -> 4.
      expectResult(4, 3);
      for (int w = 0; w < LAGS; w++) begin
         if (w == 3) begin
            repeat (3) applyStimulus(1, 0, 0, 1);
            applyStimulus(0, 1, 1, 0);
         end else begin
            repeat (2) begin
               applyStimulus(1, 0, 0, 1);
               applyStimulus(0, 1, 1, 0);
            end
         end
      end
      awaitResult();

      $display("[TB] peak in final window");
      expectResult(64, 4);
      repeat (LAGS - 1) sendWindow(1, 0, 1, 0);
      sendWindow(2, 0, 1, 0);
      awaitResult();

      $display("[TB] input gaps and downstream back-pressure");
      gapsOn = 1'b1;
      m_axis_tready = 1'b0;
      expectResult(80, 2);
      sendPeakRun();
      awaitResult();
      gapsOn = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         checkOutput("hold out_max", longint'(out_max), 80);
         checkOutput("hold index", longint'(index), 2);
         checkOutput("hold tready", s_axis_tready, 0);
      end
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("tready after hold", s_axis_tready, 1);
      checkOutput("tvalid after hold", s_axis_tvalid, 0);

      $display("[TB] reset mid-window 3");
      repeat (3 * LEN + 2) applyStimulus(1, 0, 1, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("midrun reset out_max", longint'(out_max), 0);
      checkOutput("midrun reset index", longint'(index), 0);
      checkOutput("midrun reset tready", s_axis_tready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("tready after midrun reset", s_axis_tready, 1);
      expectResult(16, 0);
      sendRun(1, 0, 1, 0);
      awaitResult();

      $display("[TB] accumulator overflow");
`ifdef X_CORR_SATURATE_EN
      expectResult(16129, 0);
`else
      // 127*127 = 16129 = 1 mod 256, so each window wraps to (4,0).
      expectResult(16, 0);
`endif
      sendRun(127, 0, 127, 0);
      awaitResult();

      repeat (5) @(posedge clk);
      #1;
      checkOutput("scoreboard empty", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
